// File: rtl/apu_resp_unit_pkg.sv
// Shared types and constants for the APU responder: opcodes, FSM states,
// flag bit positions and the small helpers used to build the flag vector.
package apu_resp_pkg;

  localparam int DATA_W = 32;
  localparam int NFLAGS = 5;

  typedef enum logic [5:0] {
    OP_ADD   = 6'd0,
    OP_SUB   = 6'd1,
    OP_MUL   = 6'd2,
    OP_MAC   = 6'd3,
    OP_ACCLD = 6'd4,
    OP_DOTP4 = 6'd5,
    OP_MIN   = 6'd6,
    OP_MAX   = 6'd7
  } apu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_RESP = 2'd2
  } apu_state_e;

  localparam int FLG_ZERO = 0;
  localparam int FLG_NEG  = 1;
  localparam int FLG_OVF  = 2;
  localparam int FLG_ILL  = 3;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic [NFLAGS-1:0] flg;
  } alu_out_t;

  // Two's-complement overflow of r = a + b.
  function automatic logic add_ovf(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                   input logic [DATA_W-1:0] r);
    return (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

  // Two's-complement overflow of r = a - b.
  function automatic logic sub_ovf(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                   input logic [DATA_W-1:0] r);
    return (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

  // Assemble the status vector; bit 4 is reserved and always zero.
  function automatic logic [NFLAGS-1:0] mk_flags(input logic [DATA_W-1:0] r, input logic ovf,
                                                 input logic ill);
    logic [NFLAGS-1:0] f;
    f           = '0;
    f[FLG_ZERO] = (r == '0);
    f[FLG_NEG]  = r[DATA_W-1];
    f[FLG_OVF]  = ovf;
    f[FLG_ILL]  = ill;
    return f;
  endfunction

endpackage

// File: rtl/apu_resp_unit_if.sv
// APU request/response handshake between the core (master) and this responder (slave).
interface apu_resp_unit_if #(
  parameter int APU_NUSFLAGS = 5
);
  logic                    apu_req_i;
  logic                    apu_gnt_o;
  logic [2:0][31:0]        apu_operands_i;
  logic [5:0]              apu_op_i;
  logic [14:0]             apu_flags_i;
  logic                    apu_rvalid_o;
  logic [31:0]             apu_result_o;
  logic [APU_NUSFLAGS-1:0] apu_flags_o;

  modport master (
    output apu_req_i, apu_operands_i, apu_op_i, apu_flags_i,
    input  apu_gnt_o, apu_rvalid_o, apu_result_o, apu_flags_o
  );

  modport slave (
    input  apu_req_i, apu_operands_i, apu_op_i, apu_flags_i,
    output apu_gnt_o, apu_rvalid_o, apu_result_o, apu_flags_o
  );
endinterface

// File: rtl/apu_resp_unit_iter_mul.sv
// Iterative shift-add multiplier: retires MUL_BITS_PER_CYCLE multiplier bits
// per cycle and produces the low 32 bits of a*b after 32/MUL_BITS_PER_CYCLE cycles.
// done is high in the final iteration cycle, with p already including that step.
module apu_iter_mul #(
  parameter int MUL_BITS_PER_CYCLE = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] p
);

  localparam int N_ITER = 32 / MUL_BITS_PER_CYCLE;
  localparam int CNT_W  = $clog2(N_ITER);

  logic             run;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      mcand;
  logic [31:0]      mplier;
  logic [31:0]      partial;
  logic [31:0]      step;

  // Partial product contributed by the lowest multiplier digit this cycle.
  assign step = mcand * {{(32-MUL_BITS_PER_CYCLE){1'b0}}, mplier[MUL_BITS_PER_CYCLE-1:0]};
  assign done = run && (cnt == '0);
  assign p    = partial + step;

  // Iteration control: fixed N_ITER cycles per operation, no early exit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= CNT_W'(N_ITER - 1);
    end else if (run) begin
      if (cnt == '0) begin
        run <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Datapath: shift multiplicand up, multiplier down, accumulate partials.
  always_ff @(posedge clk_i) begin
    if (start) begin
      mcand   <= a;
      mplier  <= b;
      partial <= '0;
    end else if (run) begin
      partial <= partial + step;
      mcand   <= mcand << MUL_BITS_PER_CYCLE;
      mplier  <= mplier >> MUL_BITS_PER_CYCLE;
    end
  end

endmodule

// File: rtl/apu_resp_unit.sv
// APU responder: grants one request at a time, computes single-cycle ALU/DSP
// ops directly and hands MUL/MAC to the iterative multiplier, then strobes
// apu_rvalid_o for one cycle with the registered result and flags.
module apu_resp_unit
  import apu_resp_pkg::*;
#(
  parameter int MUL_BITS_PER_CYCLE = 2,
  parameter int APU_NUSFLAGS       = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  apu_resp_unit_if.slave   apu,
  output logic             busy_o
);

  apu_state_e          state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                acc_ld;
  logic [DATA_W-1:0]   res_p1, res_d;
  logic [NFLAGS-1:0]   flg_p1, flg_d;
  logic                res_ld;
  logic                vld_p2;
  logic                is_mac_q;
  logic                mul_start;
  logic                mul_done;
  logic [DATA_W-1:0]   mul_p;
  logic [DATA_W-1:0]   mac_sum;
  logic                is_mulop;
  logic [DATA_W-1:0]   op0, op1, op2;
  alu_out_t            single;
  logic                unused_flags;

  // Single-cycle ALU/DSP ops; MUL/MAC never reach here, so they fall into the
  // illegal branch harmlessly.
  function automatic alu_out_t alu_single(input logic [5:0] op, input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] c);
    alu_out_t           o;
    logic [DATA_W-1:0]  r;
    logic signed [31:0] sa, sb, dsum;
    logic signed [7:0]  xa, xb;
    logic signed [15:0] pr;
    logic               ovf, ill;
    r    = '0;
    ovf  = 1'b0;
    ill  = 1'b0;
    sa   = a;
    sb   = b;
    dsum = c;
    xa   = '0;
    xb   = '0;
    pr   = '0;
    case (op)
      OP_ADD: begin
        r   = a + b;
        ovf = add_ovf(a, b, r);
      end
      OP_SUB: begin
        r   = a - b;
        ovf = sub_ovf(a, b, r);
      end
      OP_ACCLD: r = a;
      OP_DOTP4: begin
        for (int i = 0; i < 4; i++) begin
          xa   = a[8*i +: 8];
          xb   = b[8*i +: 8];
          pr   = xa * xb;
          dsum = dsum + {{16{pr[15]}}, pr};
        end
        r = dsum;
      end
      OP_MIN: r = (sa < sb) ? a : b;
      OP_MAX: r = (sa > sb) ? a : b;
      default: begin
        r   = '0;
        ill = 1'b1;
      end
    endcase
    o.res = r;
    o.flg = mk_flags(r, ovf, ill);
    return o;
  endfunction

  assign op0          = apu.apu_operands_i[0];
  assign op1          = apu.apu_operands_i[1];
  assign op2          = apu.apu_operands_i[2];
  assign unused_flags = ^apu.apu_flags_i;
  assign is_mulop     = (apu.apu_op_i == OP_MUL) || (apu.apu_op_i == OP_MAC);
  assign single       = alu_single(apu.apu_op_i, op0, op1, op2);
  assign mac_sum      = acc_q + mul_p;

  assign apu.apu_gnt_o    = apu.apu_req_i & (state_q == ST_IDLE);
  assign apu.apu_rvalid_o = vld_p2;
  assign apu.apu_result_o = res_p1;
  assign apu.apu_flags_o  = APU_NUSFLAGS'(flg_p1);
  assign busy_o           = (state_q != ST_IDLE);

  apu_iter_mul #(
    .MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
  ) u_mul (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .start (mul_start),
    .a     (op0),
    .b     (op1),
    .done  (mul_done),
    .p     (mul_p)
  );

  // Next-state logic plus result/accumulator load decisions.
  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    res_ld    = 1'b0;
    res_d     = '0;
    flg_d     = '0;
    acc_ld    = 1'b0;
    acc_d     = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (apu.apu_gnt_o) begin
          if (is_mulop) begin
            mul_start = 1'b1;
            state_d   = ST_ITER;
          end else begin
            res_ld  = 1'b1;
            res_d   = single.res;
            flg_d   = single.flg;
            state_d = ST_RESP;
            if (apu.apu_op_i == OP_ACCLD) begin
              acc_ld = 1'b1;
              acc_d  = op0;
            end
          end
        end
      end
      ST_ITER: begin
        if (mul_done) begin
          res_ld  = 1'b1;
          state_d = ST_RESP;
          if (is_mac_q) begin
            acc_ld = 1'b1;
            acc_d  = mac_sum;
            res_d  = mac_sum;
            flg_d  = mk_flags(mac_sum, add_ovf(acc_q, mul_p, mac_sum), 1'b0);
          end else begin
            res_d  = mul_p;
            flg_d  = mk_flags(mul_p, 1'b0, 1'b0);
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, accumulator and response registers; stage 1 holds result/flags,
  // stage 2 is the rvalid strobe one cycle after entering RESP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      res_p1   <= '0;
      flg_p1   <= '0;
      vld_p2   <= 1'b0;
      is_mac_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p2  <= (state_q == ST_RESP);
      if (acc_ld) begin
        acc_q <= acc_d;
      end
      if (res_ld) begin
        res_p1 <= res_d;
        flg_p1 <= flg_d;
      end
      if (mul_start) begin
        is_mac_q <= (apu.apu_op_i == OP_MAC);
      end
    end
  end

endmodule

// File: doc/apu_resp_unit.md
Name: apu_resp_unit

Overview:
- APU-side responder for the fabric-controller core: accepts one offloaded operation per request over the cv32e40p APU handshake and returns a result plus status flags.
- Supports single-cycle ALU/DSP ops and an iterative shift-add multiplier with an internal accumulator.
- Sits beside the core in the FC subsystem as an alternative APU target; it has no memory-bus master port.

Parameters:
- MUL_BITS_PER_CYCLE, 2, multiplier bits retired per iteration cycle; legal values 1, 2, 4. Iteration count N_ITER = 32/MUL_BITS_PER_CYCLE.
- APU_NUSFLAGS, 5, width of the returned flag vector.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- apu_req_i  in  1  operation request
- apu_gnt_o  out  1  request accepted this cycle
- apu_operands_i  in  3x32  op0, op1, op2
- apu_op_i  in  6  opcode
- apu_flags_i  in  15  ignored; reserved
- apu_rvalid_o  out  1  single-cycle result strobe
- apu_result_o  out  32  result, valid with apu_rvalid_o
- apu_flags_o  out  APU_NUSFLAGS  status, valid with apu_rvalid_o
- busy_o  out  1  state != IDLE

Behaviour:
- Reset values (asynchronous, rst_ni low):
  - state = IDLE; accumulator acc = 0.
  - apu_gnt_o = 0, apu_rvalid_o = 0, apu_result_o = 0, apu_flags_o = 0, busy_o = 0.
- Grant and capture:
  - apu_gnt_o = apu_req_i & (state==IDLE). This is combinational, same-cycle grant.
  - Operands and opcode are captured only on the gnt cycle.
  - Exactly one operation is outstanding at a time.
- States: IDLE, ITER, RESP.
  - IDLE with gnt, single-cycle op: compute, register result and flags, go to RESP.
  - IDLE with gnt, MUL or MAC: load multiplicand, multiplier and partial = 0; cnt = N_ITER-1; go to ITER.
  - ITER: partial += multiplicand * multiplier[MUL_BITS_PER_CYCLE-1:0]; multiplicand <<= MUL_BITS_PER_CYCLE; multiplier >>= MUL_BITS_PER_CYCLE. When cnt == 0, finalize and go to RESP; otherwise cnt--.
  - RESP: apu_rvalid_o = 1 for exactly one cycle; return to IDLE. No grant is given in RESP, so back-to-back ops are spaced by at least 1 idle cycle.
- Latency, counted from the gnt cycle (cycle 0):
  - Single-cycle ops: rvalid in cycle 2.
  - MUL/MAC: rvalid in cycle N_ITER+2, which is 18 at the default parameter value.
- apu_result_o and apu_flags_o hold their last value outside rvalid. They change only on entry to RESP.
- Opcodes (apu_op_i[5:0]):
  - 0 ADD: op0+op1.
  - 1 SUB: op0-op1.
  - 2 MUL: low 32 bits of op0*op1. The result is identical for signed and unsigned operands.
  - 3 MAC: acc <= acc + low32(op0*op1); result = new acc. acc updates on the RESP-entry cycle.
  - 4 ACCLD: acc <= op0; result = op0.
  - 5 DOTP4: sum over i=0..3 of signed byte op0[i] * signed byte op1[i], plus op2; 32-bit wrap.
  - 6 MIN: signed minimum of op0, op1.
  - 7 MAX: signed maximum of op0, op1.
  - 8..63: illegal. Result 0, flags[3]=1, single-cycle latency. acc is unchanged.
- Flags:
  - [0] zero: result==0.
  - [1] negative: result[31].
  - [2] signed overflow: ADD, SUB and the MAC final add only; 0 otherwise.
  - [3] illegal opcode.
  - [4] always 0.
- Arithmetic: all results wrap mod 2^32; there is no saturation.
- Boundary conditions:
  - apu_req_i while busy: no gnt. The requester must hold its request.
  - Reset asserted mid-ITER: the operation is abandoned, no rvalid is produced, and acc = 0.
  - apu_op_i and operands changing while busy are ignored.
  - MUL with op1==0 still takes the full N_ITER cycles; there is no early exit.

Decomposition:
- Package apu_resp_pkg holds:
  - the opcode enum (OP_ADD … OP_MAX);
  - the state enum;
  - flag bit index constants (FLG_ZERO, FLG_NEG, FLG_OVF, FLG_ILL).
- Sub-module apu_iter_mul holds the iterative shift-add multiplier:
  - Inputs: start, a, b.
  - Outputs: done, p[31:0].
  - Parameter: MUL_BITS_PER_CYCLE.

Test Plan:
1. Reset behaviour: assert reset → all outputs 0. Then ADD 0x7FFFFFFF+1 → gnt same cycle; rvalid 2 cycles later; result 0x80000000; flags 5'b00110.
2. MUL 0xFFFFFFFF*0xFFFFFFFF (default parameter) → rvalid at cycle 18; result 0x00000001; flags 0. Repeat with MUL_BITS_PER_CYCLE=1 and 4 → rvalid at cycles 34 and 10 respectively.
3. MAC sequence: ACCLD 10, then MAC 3*4, then MAC (-2)*5 → results 10, 22, 12.
4. DOTP4 with op0=0x01FF7F80, op1=0x02020202, op2=100 → result 100+2-2+254-256 = 98.
5. Request held high during a MUL → apu_gnt_o=0 for every busy cycle; the second op is granted in the first IDLE cycle after rvalid.
6. Edge cases:
   - Opcode 9 → result 0, flags 5'b01001.
   - Reset pulsed at ITER cycle 5 → no rvalid; busy_o=0; a subsequent MAC 1*1 returns 1.
